// File: rtl/polaris_pkg.sv
// Polaris RV64I-subset core: opcodes, bus size encodings, FSM states and decode legality.
// Build option POLARIS_OP32_EN: makes OP-32 (ADDW/SUBW/SLLW/SRLW/SRAW) legal instead of jamming.
package polaris_pkg;

    localparam logic [63:0] RESET_PC_DEF = 64'hFFFF_FFFF_FFFF_FF00;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [1:0] SIZ_B = 2'b00;
    localparam logic [1:0] SIZ_H = 2'b01;
    localparam logic [1:0] SIZ_W = 2'b10;
    localparam logic [1:0] SIZ_D = 2'b11;

    localparam logic [1:0] ISIZ_IDLE = 2'b00;
    localparam logic [1:0] ISIZ_WORD = SIZ_W;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_RD2,
        ST_EXEC,
        ST_WB,
        ST_MEM,
        ST_JAM
    } state_e;

    function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7);
        logic ok;
        logic f7_std;
        f7_std = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        ok = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: ok = 1'b1;
            OPC_JALR:           ok = (f3 == 3'b000);
            OPC_LOAD:           ok = (f3 != 3'b111);
            OPC_STORE:          ok = !f3[2];
            OPC_OP_IMM: begin
                // 64-bit shifts borrow f7[0] as shamt[5]
                if (f3 == 3'b001)
                    ok = (f7[6:1] == 6'b000000);
                else if (f3 == 3'b101)
                    ok = (f7[6:1] == 6'b000000) || (f7[6:1] == 6'b010000);
                else
                    ok = 1'b1;
            end
            OPC_OP_IMM_32: begin
                if (f3 == 3'b000)
                    ok = 1'b1;
                else if (f3 == 3'b001)
                    ok = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    ok = f7_std;
                else
                    ok = 1'b0;
            end
            OPC_OP: ok = (f3 == 3'b000 || f3 == 3'b101) ? f7_std : (f7 == 7'b0000000);
`ifdef POLARIS_OP32_EN
            OPC_OP_32: ok = (f3 == 3'b000 || f3 == 3'b101) ? f7_std
                          : ((f3 == 3'b001) && (f7 == 7'b0000000));
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/polaris_regfile.sv
// 32x64 register file with a single shared read/write address; x0 reads as zero.
module polaris_regfile (
    input  logic        clk_i,
    input  logic [4:0]  ra_i,
    input  logic        rwe_i,
    input  logic [63:0] rdat_i,
    output logic [63:0] rdat_o
);

    logic [63:0] mem_q [0:31];

    always_ff @(posedge clk_i) begin
        if (rwe_i && (ra_i != 5'd0))
            mem_q[ra_i] <= rdat_i;
    end

    assign rdat_o = (ra_i == 5'd0) ? 64'd0 : mem_q[ra_i];

endmodule

// File: rtl/polaris_cpu.sv
// Multi-cycle RV64I-subset core; OP-32 support selected by POLARIS_OP32_EN.
//   state  | meaning
//   RESET  | first cycle after reset, bus idle
//   FETCH  | isiz_o=10 at PC until iack_i
//   DECODE | legality check, rs1 -> A, upper-immediate result -> R
//   RD2    | rs2 -> B
//   EXEC   | ALU / link result -> R
//   WB     | R -> rd, PC update
//   MEM    | data bus cycle until dack_i
//   JAM    | halted on illegal instruction until reset
module polaris_cpu
    import polaris_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        jammed_o,
    input  logic        iack_i,
    input  logic [31:0] idat_i,
    output logic [63:0] iadr_o,
    output logic [1:0]  isiz_o,
    input  logic        dack_i,
    input  logic [63:0] ddat_i,
    output logic [63:0] ddat_o,
    output logic [63:0] dadr_o,
    output logic        dwe_o,
    output logic        dcyc_o,
    output logic        dstb_o,
    output logic [1:0]  dsiz_o,
    output logic        dsigned_o
);

    state_e      state_q, state_d;
    logic [63:0] pc_q;
    logic [31:0] ir_q;
    logic [63:0] a_q, b_q, r_q;

    logic [4:0]  rf_ra;
    logic        rf_we;
    logic [63:0] rf_wdat, rf_rdat;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm_i, imm_s, imm_u;
    logic        is_store, is_word, is_reg_op;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    assign imm_i = {{52{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{52{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_u = {{32{ir_q[31]}}, ir_q[31:12], 12'd0};

    assign is_store  = (opc == OPC_STORE);
    assign is_word   = (opc == OPC_OP_IMM_32) || (opc == OPC_OP_32);
    assign is_reg_op = (opc == OPC_OP) || (opc == OPC_OP_32);

    polaris_regfile u_regfile (
        .clk_i  (clk_i),
        .ra_i   (rf_ra),
        .rwe_i  (rf_we),
        .rdat_i (rf_wdat),
        .rdat_o (rf_rdat)
    );

    logic [63:0] op2, sum64, sr64, alu64, exec_res;
    logic [31:0] sr32, w32;
    logic [5:0]  sh6;
    logic        sub;

    always_comb begin
        op2   = is_reg_op ? b_q : imm_i;
        sh6   = is_word ? {1'b0, op2[4:0]} : op2[5:0];
        sub   = is_reg_op && f7[5];
        sum64 = sub ? (a_q - op2) : (a_q + op2);
        // ir_q[30] selects arithmetic right shift for both register and immediate forms
        if (ir_q[30])
            sr64 = $signed(a_q) >>> sh6;
        else
            sr64 = a_q >> sh6;
        if (ir_q[30])
            sr32 = $signed(a_q[31:0]) >>> sh6[4:0];
        else
            sr32 = a_q[31:0] >> sh6[4:0];

        alu64 = sum64;
        case (f3)
            3'b000: alu64 = sum64;
            3'b001: alu64 = a_q << sh6;
            3'b010: alu64 = {63'd0, $signed(a_q) < $signed(op2)};
            3'b011: alu64 = {63'd0, a_q < op2};
            3'b100: alu64 = a_q ^ op2;
            3'b101: alu64 = sr64;
            3'b110: alu64 = a_q | op2;
            3'b111: alu64 = a_q & op2;
            default: alu64 = sum64;
        endcase

        w32 = sum64[31:0];
        if (f3 == 3'b001)
            w32 = a_q[31:0] << sh6[4:0];
        else if (f3 == 3'b101)
            w32 = sr32;

        if (opc == OPC_JALR)
            exec_res = pc_q + 64'd4;
        else if (is_word)
            exec_res = {{32{w32[31]}}, w32};
        else
            exec_res = alu64;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            state_q <= ST_RESET;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  if (iack_i) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!is_legal(opc, f3, f7))
                    state_d = ST_JAM;
                else if (opc == OPC_LUI || opc == OPC_AUIPC)
                    state_d = ST_WB;
                else if (opc == OPC_OP_IMM || opc == OPC_OP_IMM_32)
                    state_d = ST_EXEC;
                else
                    state_d = ST_RD2;
            end
            ST_RD2:    state_d = (opc == OPC_LOAD || is_store) ? ST_MEM : ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_MEM:    if (dack_i) state_d = ST_FETCH;
            ST_JAM:    state_d = ST_JAM;
            default:   state_d = ST_JAM;
        endcase
    end

    always_comb begin
        isiz_o    = (state_q == ST_FETCH) ? ISIZ_WORD : ISIZ_IDLE;
        jammed_o  = (state_q == ST_JAM);
        iadr_o    = pc_q;
        dcyc_o    = 1'b0;
        dstb_o    = 1'b0;
        dwe_o     = 1'b0;
        dsigned_o = 1'b0;
        dsiz_o    = SIZ_B;
        dadr_o    = 64'd0;
        ddat_o    = 64'd0;
        rf_ra     = rs1;
        rf_we     = 1'b0;
        rf_wdat   = r_q;
        case (state_q)
            ST_RD2: rf_ra = rs2;
            ST_WB: begin
                rf_ra = rd;
                rf_we = 1'b1;
            end
            ST_MEM: begin
                dcyc_o    = 1'b1;
                dstb_o    = 1'b1;
                dwe_o     = is_store;
                dsigned_o = !is_store && !f3[2];
                dsiz_o    = f3[1:0];
                dadr_o    = a_q + (is_store ? imm_s : imm_i);
                ddat_o    = b_q;
                rf_ra     = rd;
                rf_we     = dack_i && !is_store;
                rf_wdat   = ddat_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_q <= RESET_PC;
            ir_q <= 32'd0;
            a_q  <= 64'd0;
            b_q  <= 64'd0;
            r_q  <= 64'd0;
        end else begin
            case (state_q)
                ST_FETCH:  if (iack_i) ir_q <= idat_i;
                ST_DECODE: begin
                    a_q <= rf_rdat;
                    r_q <= ((opc == OPC_AUIPC) ? pc_q : 64'd0) + imm_u;
                end
                ST_RD2:    b_q <= rf_rdat;
                ST_EXEC:   r_q <= exec_res;
                ST_WB:     pc_q <= (opc == OPC_JALR) ? ((a_q + imm_i) & ~64'd1)
                                                     : (pc_q + 64'd4);
                ST_MEM:    if (dack_i) pc_q <= pc_q + 64'd4;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polaris_cpu.sv
// Directed bench for polaris_cpu: instruction table plus hand sequences for bus and jam cases.
module tb_polaris_cpu;

    localparam int OP_IMM = 'h13, OP_IMM32 = 'h1B, OP = 'h33, OP32 = 'h3B;
    localparam int LUI = 'h37, AUIPC = 'h17, JALR = 'h67, LOAD = 'h03;
    localparam logic [63:0] RST_PC = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] P = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] Q = 64'hFFFF_AAAA_5555_FFFE;
    localparam logic [63:0] R = 64'hFFFF_FFFF_FFFF_5558;
    localparam logic [63:0] S = 64'hFFFF_FFFF_DEAD_B000;
    localparam logic [63:0] U = 64'hFFFF_FFFF_DEFF_F000;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        jammed_o, iack_i, dack_i, dwe_o, dcyc_o, dstb_o, dsigned_o;
    logic [31:0] idat_i;
    logic [63:0] iadr_o, ddat_i, ddat_o, dadr_o;
    logic [1:0]  isiz_o, dsiz_o;

    typedef struct {
        logic [31:0] ins;
        int          cyc;
        logic [63:0] nxt;
    } vec_t;

    vec_t prog[$];
    int checks = 0;
    int errors = 0;

    polaris_cpu dut (
        .clk_i(clk_i), .reset_i(reset_i), .jammed_o(jammed_o),
        .iack_i(iack_i), .idat_i(idat_i), .iadr_o(iadr_o), .isiz_o(isiz_o),
        .dack_i(dack_i), .ddat_i(ddat_i), .ddat_o(ddat_o), .dadr_o(dadr_o),
        .dwe_o(dwe_o), .dcyc_o(dcyc_o), .dstb_o(dstb_o), .dsiz_o(dsiz_o),
        .dsigned_o(dsigned_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic void add(logic [31:0] ins, int cyc, logic [63:0] nxt);
        vec_t v;
        v.ins = ins;
        v.cyc = cyc;
        v.nxt = nxt;
        prog.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_fetch();
        int k;
        k = 0;
        while (isiz_o != 2'b10 && k < 30) begin
            @(negedge clk_i);
            k++;
        end
        chk("fetch_ready", {62'd0, isiz_o}, 64'd2);
    endtask

    task automatic issue(input logic [31:0] ins);
        wait_fetch();
        idat_i = ins;
        iack_i = 1'b1;
        @(posedge clk_i);
        #1;
        iack_i = 1'b0;
        idat_i = 32'd0;
    endtask

    task automatic run_vec(input string name, input logic [31:0] ins, input int cyc,
                           input logic [63:0] nxt);
        int n;
        issue(ins);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (isiz_o != 2'b10 && n < 30);
        chk({name, "_cycles"}, 64'(n - 1), 64'(cyc));
        chk({name, "_next_pc"}, iadr_o, nxt);
    endtask

    task automatic mem_enter(input logic [31:0] ins);
        issue(ins);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic mem_ack(input logic [63:0] data, input logic [63:0] nxt);
        dack_i = 1'b1;
        ddat_i = data;
        @(posedge clk_i);
        #1;
        dack_i = 1'b0;
        ddat_i = 64'd0;
        @(negedge clk_i);
        chk("ack_dcyc_drop", {63'd0, dcyc_o}, 64'd0);
        chk("ack_refetch", {62'd0, isiz_o}, 64'd2);
        chk("ack_next_pc", iadr_o, nxt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iack_i = 1'b0;
        idat_i = 32'd0;
        dack_i = 1'b0;
        ddat_i = 64'd0;

        add(enc_i(0, 0, 0, 0, OP_IMM),        3, RST_PC + 4);
        add(enc_i('h124, 0, 0, 2, OP_IMM),    3, RST_PC + 8);
        add(enc_i(0, 2, 0, 0, JALR),          4, 64'h124);
        add(enc_i('h248, 0, 0, 2, OP_IMM),    3, 64'h128);
        add(enc_i(0, 2, 0, 1, JALR),          4, 64'h248);
        add(enc_i(-4, 1, 0, 0, JALR),         4, 64'h128);
        add(enc_i('h48, 2, 7, 2, OP_IMM),     3, 64'h12C);
        add(enc_i(16, 2, 1, 2, OP_IMM),       3, 64'h130);
        add(enc_i(0, 2, 0, 0, JALR),          4, 64'h0048_0000);
        add(enc_i(1, 0, 0, 3, OP_IMM),        3, 64'h0048_0004);
        add(enc_i(31, 3, 1, 3, OP_IMM32),     3, 64'h0048_0008);
        add(enc_i(0, 3, 0, 0, JALR),          4, P);
        add(enc_i('h55, 0, 0, 4, OP_IMM),     3, P + 'h4);
        add(enc_i(8, 4, 1, 4, OP_IMM),        3, P + 'h8);
        add(enc_i('h55, 4, 6, 4, OP_IMM),     3, P + 'hC);
        add(enc_i(32, 4, 1, 4, OP_IMM),       3, P + 'h10);
        add(enc_i('hAA, 0, 0, 5, OP_IMM),     3, P + 'h14);
        add(enc_i(8, 5, 1, 5, OP_IMM),        3, P + 'h18);
        add(enc_i('hAA, 5, 6, 5, OP_IMM),     3, P + 'h1C);
        add(enc_i(16, 5, 1, 5, OP_IMM),       3, P + 'h20);
        add(enc_r(0, 5, 4, 6, 4, OP),         4, P + 'h24);
        add(enc_i(-1, 0, 0, 2, OP_IMM),       3, P + 'h28);
        add(enc_r(0, 4, 2, 4, 2, OP),         4, P + 'h2C);
        add(enc_i(0, 2, 0, 0, JALR),          4, Q);
        add(enc_r('h20, 5, 0, 0, 6, OP),      4, Q + 'h4);
        add(enc_i('h410, 6, 5, 7, OP_IMM),    3, Q + 'h8);
        add(enc_r(0, 6, 5, 3, 8, OP),         4, Q + 'hC);
        add(enc_r(0, 5, 6, 2, 9, OP),         4, Q + 'h10);
        add(enc_r(0, 8, 7, 0, 7, OP),         4, Q + 'h14);
        add(enc_r(0, 9, 7, 0, 7, OP),         4, Q + 'h18);
        add(enc_i(0, 7, 0, 0, JALR),          4, R);
        add(enc_u('hDEADB, 2, LUI),           2, R + 'h4);
        add(enc_i(0, 2, 0, 0, JALR),          4, S);
        add(enc_u('h524, 5, AUIPC),           2, S + 'h4);
        add(enc_i(0, 5, 0, 0, JALR),          4, U);

        // reset and bootstrap into an all-zero (illegal) word
        repeat (3) @(negedge clk_i);
        chk("rst_iadr", iadr_o, RST_PC);
        chk("rst_ctrl", {55'd0, dcyc_o, dstb_o, dwe_o, dsigned_o, jammed_o, isiz_o, dsiz_o}, 64'd0);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("boot_isiz", {62'd0, isiz_o}, 64'd2);
        chk("boot_iadr", iadr_o, RST_PC);
        repeat (2) @(negedge clk_i);
        chk("boot_hold_isiz", {62'd0, isiz_o}, 64'd2);
        chk("boot_hold_iadr", iadr_o, RST_PC);
        issue(32'd0);
        @(negedge clk_i);
        chk("jam_decode_isiz", {62'd0, isiz_o}, 64'd0);
        chk("jam_decode_flag", {63'd0, jammed_o}, 64'd0);
        @(negedge clk_i);
        chk("jam_flag", {63'd0, jammed_o}, 64'd1);
        repeat (4) @(negedge clk_i);
        chk("jam_stays", {60'd0, jammed_o, isiz_o, dcyc_o}, 64'b1000);

        reset_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("restart_jam_clear", {63'd0, jammed_o}, 64'd0);

        foreach (prog[i])
            run_vec($sformatf("vec%0d", i), prog[i].ins, prog[i].cyc, prog[i].nxt);

        // LHU x1,0x123(x2), held without ack
        mem_enter(enc_i('h123, 2, 5, 1, LOAD));
        chk("lhu_ctrl", {59'd0, dcyc_o, dstb_o, dwe_o, dsigned_o, isiz_o == 2'b00}, 64'b11001);
        chk("lhu_dsiz", {62'd0, dsiz_o}, 64'd1);
        chk("lhu_dadr", dadr_o, 64'hFFFF_FFFF_DEAD_B123);
        repeat (2) @(negedge clk_i);
        chk("lhu_hold_cyc", {62'd0, dcyc_o, dstb_o}, 64'b11);
        chk("lhu_hold_dadr", dadr_o, 64'hFFFF_FFFF_DEAD_B123);
        mem_ack(64'h0000_0000_0000_FFFC, U + 4);

        // LB x1,4(x1) uses the loaded value as base
        mem_enter(enc_i(4, 1, 0, 1, LOAD));
        chk("lb_dadr", dadr_o, 64'h0001_0000);
        chk("lb_ctrl", {59'd0, dcyc_o, dwe_o, dsigned_o, dsiz_o}, 64'b10100);
        mem_ack(64'hFFFF_FFFF_FFFF_FF80, U + 8);
        run_vec("jalr_loaded", enc_i(0, 1, 0, 0, JALR), 4, 64'hFFFF_FFFF_FFFF_FF80);

        // SD x2,8(x0), then reset in the middle of the bus cycle
        mem_enter(enc_s(8, 2, 0, 3));
        chk("sd_ctrl", {59'd0, dcyc_o, dstb_o, dwe_o, dsigned_o, 1'b0}, 64'b11100);
        chk("sd_dsiz", {62'd0, dsiz_o}, 64'd3);
        chk("sd_dadr", dadr_o, 64'd8);
        chk("sd_ddat", ddat_o, S);
        #2;
        reset_i = 1'b0;
        #1;
        chk("abort_dcyc", {62'd0, dcyc_o, dstb_o}, 64'd0);
        chk("abort_iadr", iadr_o, RST_PC);
        chk("abort_isiz", {62'd0, isiz_o}, 64'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("abort_refetch", iadr_o, RST_PC);

        run_vec("addi_x0", enc_i('h100, 0, 0, 0, OP_IMM), 3, RST_PC + 4);
        run_vec("jalr_x0", enc_i('h40, 0, 0, 0, JALR), 4, 64'h40);

`ifdef POLARIS_OP32_EN
        run_vec("addw", enc_r(0, 0, 0, 0, 11, OP32), 4, 64'h44);
`else
        issue(enc_r(0, 0, 0, 0, 11, OP32));
        @(negedge clk_i);
        chk("op32_decode", {62'd0, jammed_o, isiz_o != 2'b00}, 64'd0);
        @(negedge clk_i);
        chk("op32_jam", {63'd0, jammed_o}, 64'd1);
        repeat (3) @(negedge clk_i);
        chk("op32_jam_idle", {60'd0, jammed_o, isiz_o, dcyc_o}, 64'b1000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
